// File: rtl/vga_rx_monitor_if.sv
// VGA receive-side bundle: the sampled video signals plus the measured timing results.
interface vga_rx_monitor_if;
    logic        VGA_CLK;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic [11:0] H_TOTAL;
    logic [11:0] H_ACTIVE;
    logic [10:0] V_TOTAL;
    logic [10:0] V_ACTIVE;
    logic [15:0] FRAME_SUM;
    logic        FRAME_VALID;
    logic        LOCKED;
    logic        TIMING_ERR;

    modport master (
        output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B,
        input  H_TOTAL, H_ACTIVE, V_TOTAL, V_ACTIVE, FRAME_SUM, FRAME_VALID, LOCKED, TIMING_ERR
    );

    modport slave (
        input  VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_R, VGA_G, VGA_B,
        output H_TOTAL, H_ACTIVE, V_TOTAL, V_ACTIVE, FRAME_SUM, FRAME_VALID, LOCKED, TIMING_ERR
    );
endinterface

// File: rtl/vga_rx_monitor.sv
// Measures VGA line/frame timing from a pixel clock sampled in the CLOCK_50 domain and checks lock.
// Define VGA_MON_CHECKSUM_EN to build the per-frame R+G+B checksum; otherwise FRAME_SUM is 0.
module vga_rx_monitor #(
    parameter int unsigned H_TOTAL_EXP  = 800,
    parameter int unsigned H_ACTIVE_EXP = 640,
    parameter int unsigned V_TOTAL_EXP  = 525,
    parameter int unsigned V_ACTIVE_EXP = 480
) (
    input logic             CLOCK_50,
    input logic             RESET,
    vga_rx_monitor_if.slave mon
);

    localparam int unsigned HW = 12;
    localparam int unsigned VW = 11;
    localparam logic [HW-1:0] H_MAX = {HW{1'b1}};
    localparam logic [VW-1:0] V_MAX = {VW{1'b1}};

    typedef enum logic {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic          vga_clk_q, hs_q, vs_q;
    logic          strobe_c, hs_fall_c, vs_fall_c, measure_c;
    logic          frame_open_c, frame_close_c;
    logic          blank_n_c;

    logic [HW-1:0] pix_cnt_q, act_cnt_q, max_act_q, last_pix_q;
    logic [VW-1:0] line_cnt_q, act_line_q;
    logic [HW-1:0] pix_inc_c, act_inc_c, max_cl_c, last_pix_cl_c;
    logic [VW-1:0] line_cl_c, act_line_cl_c;

    logic [HW-1:0] h_total_q, h_active_q;
    logic [VW-1:0] v_total_q, v_active_q;
    logic          frame_valid_q, locked_q, timing_err_q, good_q;
    logic          sat_c, match_c;

    // Pixel strobe is the rising edge of VGA_CLK; syncs are compared strobe to strobe.
    assign strobe_c  = mon.VGA_CLK & ~vga_clk_q;
    assign hs_fall_c = strobe_c & hs_q & ~mon.VGA_HS;
    assign vs_fall_c = strobe_c & vs_q & ~mon.VGA_VS;
    assign blank_n_c = mon.VGA_BLANK_N;
    assign measure_c = strobe_c & (state_q == MEASURE);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            vga_clk_q <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
        end else begin
            vga_clk_q <= mon.VGA_CLK;
            if (strobe_c) begin
                hs_q <= mon.VGA_HS;
                vs_q <= mon.VGA_VS;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) state_q <= SEEK;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        frame_open_c  = 1'b0;
        frame_close_c = 1'b0;
        case (state_q)
            SEEK: begin
                if (vs_fall_c) begin
                    state_d      = MEASURE;
                    frame_open_c = 1'b1;
                end
            end
            MEASURE: begin
                if (vs_fall_c) frame_close_c = 1'b1;
            end
            default: state_d = SEEK;
        endcase
    end

    // Values as they stand once the current strobe's line close (if any) is applied.
    always_comb begin
        pix_inc_c     = (pix_cnt_q == H_MAX) ? pix_cnt_q : pix_cnt_q + HW'(1);
        act_inc_c     = (act_cnt_q == H_MAX) ? act_cnt_q : act_cnt_q + HW'(1);
        line_cl_c     = line_cnt_q;
        act_line_cl_c = act_line_q;
        max_cl_c      = max_act_q;
        last_pix_cl_c = last_pix_q;
        if (hs_fall_c) begin
            line_cl_c     = (line_cnt_q == V_MAX) ? line_cnt_q : line_cnt_q + VW'(1);
            last_pix_cl_c = pix_cnt_q;
            if (act_cnt_q != '0)
                act_line_cl_c = (act_line_q == V_MAX) ? act_line_q : act_line_q + VW'(1);
            if (act_cnt_q > max_act_q)
                max_cl_c = act_cnt_q;
        end
    end

    // The strobe carrying a sync fall is the first pixel of the new line/frame.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            pix_cnt_q  <= '0;
            act_cnt_q  <= '0;
            max_act_q  <= '0;
            last_pix_q <= '0;
            line_cnt_q <= '0;
            act_line_q <= '0;
        end else if (frame_open_c) begin
            pix_cnt_q  <= HW'(1);
            act_cnt_q  <= HW'(blank_n_c);
            max_act_q  <= '0;
            last_pix_q <= '0;
            line_cnt_q <= '0;
            act_line_q <= '0;
        end else if (measure_c) begin
            if (hs_fall_c) begin
                pix_cnt_q <= HW'(1);
                act_cnt_q <= HW'(blank_n_c);
            end else begin
                pix_cnt_q <= pix_inc_c;
                if (blank_n_c) act_cnt_q <= act_inc_c;
            end
            last_pix_q <= last_pix_cl_c;
            if (frame_close_c) begin
                line_cnt_q <= '0;
                act_line_q <= '0;
                max_act_q  <= '0;
            end else begin
                line_cnt_q <= line_cl_c;
                act_line_q <= act_line_cl_c;
                max_act_q  <= max_cl_c;
            end
        end
    end

    assign sat_c   = (last_pix_cl_c == H_MAX) || (max_cl_c == H_MAX) ||
                     (line_cl_c == V_MAX) || (act_line_cl_c == V_MAX);
    assign match_c = !sat_c &&
                     (last_pix_cl_c == HW'(H_TOTAL_EXP))  &&
                     (max_cl_c      == HW'(H_ACTIVE_EXP)) &&
                     (line_cl_c     == VW'(V_TOTAL_EXP))  &&
                     (act_line_cl_c == VW'(V_ACTIVE_EXP));

    // Result latch and lock tracking; good_q remembers whether the previous frame matched.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            h_total_q     <= '0;
            h_active_q    <= '0;
            v_total_q     <= '0;
            v_active_q    <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
            good_q        <= 1'b0;
        end else begin
            frame_valid_q <= frame_close_c;
            if (frame_close_c) begin
                h_total_q  <= last_pix_cl_c;
                h_active_q <= max_cl_c;
                v_total_q  <= line_cl_c;
                v_active_q <= act_line_cl_c;
                if (match_c) begin
                    locked_q <= good_q;
                    good_q   <= 1'b1;
                end else begin
                    locked_q <= 1'b0;
                    good_q   <= 1'b0;
                    if (locked_q) timing_err_q <= 1'b1;
                end
            end
        end
    end

`ifdef VGA_MON_CHECKSUM_EN
    logic [9:0]  pix_rgb_c;
    logic [15:0] sum_q, frame_sum_q;

    assign pix_rgb_c = 10'(mon.VGA_R) + 10'(mon.VGA_G) + 10'(mon.VGA_B);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sum_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            if (frame_open_c || frame_close_c)
                sum_q <= blank_n_c ? 16'(pix_rgb_c) : '0;
            else if (measure_c && blank_n_c)
                sum_q <= sum_q + 16'(pix_rgb_c);
            if (frame_close_c) frame_sum_q <= sum_q;
        end
    end

    assign mon.FRAME_SUM = frame_sum_q;
`else
    logic unused_rgb;
    assign unused_rgb    = ^{mon.VGA_R, mon.VGA_G, mon.VGA_B};
    assign mon.FRAME_SUM = '0;
`endif

    assign mon.H_TOTAL     = h_total_q;
    assign mon.H_ACTIVE    = h_active_q;
    assign mon.V_TOTAL     = v_total_q;
    assign mon.V_ACTIVE    = v_active_q;
    assign mon.FRAME_VALID = frame_valid_q;
    assign mon.LOCKED      = locked_q;
    assign mon.TIMING_ERR  = timing_err_q;

endmodule
